// File: rtl/fp_mul_result_buffer_pkg.sv
// Shared floating-point constants: exception bit positions, rounding modes,
// and small helpers used by the multiplier result buffer.
package fp_mul_result_buffer_pkg;

    // Exception vector layout produced by FloatingPointMul
    localparam int EXC_W         = 5;
    localparam int EXC_INVALID   = 4;
    localparam int EXC_DIVBYZERO = 3;
    localparam int EXC_OVERFLOW  = 2;
    localparam int EXC_UNDERFLOW = 1;
    localparam int EXC_INEXACT   = 0;

    typedef logic [EXC_W-1:0] exc_t;

    // Rounding-mode encodings shared across the FP datapath
    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } round_mode_e;

    // Builds an exception vector from individual flags in the shared bit order
    function automatic exc_t make_exc(input logic nv, input logic dz, input logic of,
                                      input logic uf, input logic nx);
        exc_t e;
        e                = '0;
        e[EXC_INVALID]   = nv;
        e[EXC_DIVBYZERO] = dz;
        e[EXC_OVERFLOW]  = of;
        e[EXC_UNDERFLOW] = uf;
        e[EXC_INEXACT]   = nx;
        return e;
    endfunction

endpackage

// File: rtl/fp_mul_result_buffer_sticky_flags.sv
// Sticky accumulated exception flags: each bit is set by an accepted
// exception and held until an explicit clear or reset.
module fp_sticky_flags
    import fp_mul_result_buffer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       set_en,
    input  exc_t       set_flags,
    output exc_t       flags
);

    genvar gi;
    generate
        for (gi = 0; gi < EXC_W; gi++) begin : g_bit
            logic flag_reg;

            // Clear drops the old value; a new exception in the same cycle still lands
            always_ff @(posedge clk) begin
                if (rst) begin
                    flag_reg <= 1'b0;
                end else begin
                    flag_reg <= (flag_reg & ~clr) | (set_en & set_flags[gi]);
                end
            end

            assign flags[gi] = flag_reg;
        end
    endgenerate

endmodule

// File: rtl/fp_mul_result_buffer.sv
// Small in-order FIFO holding multiplier results and their exception vectors,
// with occupancy output, flush, and sticky accumulated exception flags.
module fp_mul_result_buffer
    import fp_mul_result_buffer_pkg::*;
#(
    parameter int exp_width  = 8,
    parameter int frac_width = 23,
    parameter int depth      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [exp_width+frac_width:0]     in_result,
    input  logic [EXC_W-1:0]                  in_exception,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [exp_width+frac_width:0]     out_result,
    output logic [EXC_W-1:0]                  out_exception,
    output logic [$clog2(depth):0]            count,
    output logic [EXC_W-1:0]                  fflags,
    input  logic                              flags_clr,
    input  logic                              flush
);

    localparam int RES_W = exp_width + frac_width + 1;
    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;

    // Storage is read asynchronously so a freshly pushed entry shows up one
    // cycle later without a prefetch stage; depth is small.
    logic [RES_W-1:0] res_mem [depth];
    exc_t             exc_mem [depth];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;

    logic push;
    logic pop;
    logic not_empty;

    assign not_empty = (count_reg != '0);
    assign in_ready  = (count_reg != CNT_W'(depth)) && !flush;
    assign out_valid = not_empty;
    assign push      = in_valid && in_ready;
    // A pop coinciding with flush is dropped; the flush empties the buffer anyway
    assign pop       = out_valid && out_ready && !flush;

    assign out_result    = not_empty ? res_mem[rd_ptr_reg] : '0;
    assign out_exception = not_empty ? exc_mem[rd_ptr_reg] : '0;
    assign count         = count_reg;

    // Write the accepted entry at the tail; contents need no reset since
    // the outputs are masked while empty
    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr_reg] <= in_result;
            exc_mem[wr_ptr_reg] <= in_exception;
        end
    end

    // Next pointer/occupancy; pointers wrap naturally at the power-of-two depth
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and occupancy registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Flags accumulate only exceptions of entries actually accepted
    fp_sticky_flags u_sticky_flags (
        .clk       (clk),
        .rst       (rst),
        .clr       (flags_clr),
        .set_en    (push),
        .set_flags (in_exception),
        .flags     (fflags)
    );

endmodule

// File: doc/fp_mul_result_buffer.md
FP_MUL_RESULT_BUFFER -- requirements
Module: fp_mul_result_buffer

Interface
REQ-001 SHALL have parameter exp_width, default 8, exponent field width of the multiplier result.
REQ-002 SHALL have parameter frac_width, default 23, fraction field width of the multiplier result.
REQ-003 SHALL have parameter depth, default 4, number of entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, a multiplier result is presented.
REQ-007 SHALL have port in_ready, output, 1, the buffer accepts when high.
REQ-008 SHALL have port in_result, input, exp_width+frac_width+1, packed sign/exponent/fraction from FloatingPointMul.
REQ-009 SHALL have port in_exception, input, 5, exception vector from FloatingPointMul.
REQ-010 SHALL have port out_valid, output, 1, the head entry is valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer takes the head entry.
REQ-012 SHALL have port out_result, output, exp_width+frac_width+1, head entry result.
REQ-013 SHALL have port out_exception, output, 5, head entry exception vector.
REQ-014 SHALL have port count, output, $clog2(depth)+1, current occupancy.
REQ-015 SHALL have port fflags, output, 5, sticky OR of the exceptions of all accepted entries.
REQ-016 SHALL have port flags_clr, input, 1, clears fflags.
REQ-017 SHALL have port flush, input, 1, discards all entries.

Function
REQ-018 SHALL accept (push) exactly on a cycle with in_valid && in_ready, and release (pop) exactly on a cycle with out_valid && out_ready.
REQ-019 SHALL drive in_ready = (count != depth) && !flush; no same-cycle bypass when full, even if out_ready is high.
REQ-020 SHALL drive out_valid = (count != 0); out_result and out_exception SHALL be all-zero while count == 0.
REQ-021 SHALL make a pushed entry visible at the output on the cycle after the push (latency 1 cycle); zero-cycle flow-through is not permitted.
REQ-022 SHALL deliver entries in strict push order, with result and exception bit-exact.
REQ-023 SHALL on a simultaneous push and pop with 0 < count < depth leave count unchanged and advance both pointers.
REQ-024 SHALL wrap the read and write pointers modulo depth without losing or duplicating entries.
REQ-025 SHALL hold out_result and out_exception stable while out_valid && !out_ready.
REQ-026 SHALL on flush set count to 0 and both pointers to 0 next cycle; a pop asserted in the flush cycle is ignored; fflags are unaffected.
REQ-027 SHALL update fflags next cycle as (flags_clr ? 0 : fflags) | (push ? in_exception : 0); clear and set in the same cycle leave only the new exception.
REQ-028 SHALL use exception bit positions from the shared constants: invalid 4, divbyzero 3, overflow 2, underflow 1, inexact 0.

Reset
REQ-029 SHALL on rst set count, both pointers and fflags to 0, giving out_valid 0, in_ready 1, and out_result/out_exception 0.
REQ-030 SHALL let rst dominate flush, push, pop and flags_clr in the same cycle; an entry in flight is discarded.

Structure
REQ-031 SHALL take the exception bit indices and round-mode encodings from the shared FP constants package/header; no local redefinition.
REQ-032 SHALL place the sticky-flag register in one sub-module, fp_sticky_flags; the storage and pointers SHALL be inline.

Verification
REQ-033 SHALL cover: push 0x3F800000 with exc 0 at cycle N, out_ready 1 -> out_valid at N+1 with out_result 0x3F800000, count 0 at N+2.
REQ-034 SHALL cover: 4 pushes with out_ready 0 -> count 4, in_ready 0; a 5th in_valid is not accepted; draining yields the 4 values in order.
REQ-035 SHALL cover: push exc 5'b00100, then exc 5'b00001 -> fflags 5'b00101; flags_clr together with a push of exc 5'b00010 -> fflags 5'b00010.
REQ-036 SHALL cover: 10 back-to-back push/pop pairs starting at count 2 -> count stays 2 across pointer wrap, data in order.
REQ-037 SHALL cover: flush with count 3 and a concurrent push -> count 0, out_valid 0 next cycle, fflags retained.
REQ-038 SHALL cover: rst asserted with count 2 and fflags 5'b00100 -> count 0, fflags 0, in_ready 1 next cycle.
